// File: rtl/output_port_reader_pkg.sv
// Shared defaults, select-width helper and FSM encoding for the output port reader.
package output_port_reader_pkg;

    localparam int PORT_NUB_TOTAL_DFLT = 4;
    localparam int DATA_WIDTH_DFLT     = 16;
    localparam int LEN_WIDTH_DFLT      = 8;

    // A single-source port still needs a 1-bit select so that ports stay legal.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_HDR_RD   = 3'd2,
        ST_HDR_WAIT = 3'd3,
        ST_BODY     = 3'd4,
        ST_DONE     = 3'd5,
        ST_GAP      = 3'd6
    } rd_state_e;

endpackage

// File: rtl/output_port_reader_fifo.sv
// Two-entry output FIFO; the head entry stays put until popped, so the sink sees stable words.
module out_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/output_port_reader.sv
// Reads whole packets (header + body) from round-robin selected source queues into one tx stream.
//  state    | meaning
//  IDLE     | no source has a complete packet
//  ARB      | round-robin grant from last_grant+1
//  HDR_RD   | issue header read once the FIFO has room
//  HDR_WAIT | header on data_in, latch body length
//  BODY     | stream body reads while FIFO has room
//  DONE     | pulse rd_done to the granted source
//  GAP      | let empty_in reflect the decrement
module output_port_reader
    import output_port_reader_pkg::*;
#(
    parameter  int PORT_NUB_TOTAL = PORT_NUB_TOTAL_DFLT,
    parameter  int DATA_WIDTH     = DATA_WIDTH_DFLT,
    parameter  int LEN_WIDTH      = LEN_WIDTH_DFLT,
    localparam int WIDTH_SEL      = sel_width(PORT_NUB_TOTAL)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORT_NUB_TOTAL-1:0] empty_in,
    output logic [WIDTH_SEL-1:0]      rd_sel,
    output logic                      rd_en,
    output logic                      rd_done,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_sop,
    output logic                      tx_eop,
    output logic [WIDTH_SEL-1:0]      tx_src,
    output logic                      busy
);

    localparam int FW = 2 + WIDTH_SEL + DATA_WIDTH;

    rd_state_e            state_q, state_d;
    logic [WIDTH_SEL-1:0] sel_q, sel_d;
    logic [WIDTH_SEL-1:0] last_grant_q, last_grant_d;
    logic [WIDTH_SEL-1:0] grant_idx;
    logic                 grant_found;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0] hdr_len;
    logic                 inflight_q;
    logic                 last_q, last_d;
    logic                 push, pop, room;
    logic                 push_sop, push_eop;
    logic [1:0]           fifo_cnt;
    logic [FW-1:0]        push_word, head_word;

    assign hdr_len = data_in[LEN_WIDTH-1:0];
    assign pop     = tx_valid & tx_ready;
    assign push    = inflight_q;
    // A pop this cycle frees a slot in time for a read issued now, which keeps the body at one word per cycle.
    assign room    = ({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    always_comb begin
        logic [WIDTH_SEL:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= PORT_NUB_TOTAL; k++) begin
            cand = {1'b0, last_grant_q} + (WIDTH_SEL+1)'(k);
            if (cand >= (WIDTH_SEL+1)'(PORT_NUB_TOTAL)) begin
                cand = cand - (WIDTH_SEL+1)'(PORT_NUB_TOTAL);
            end
            if (!grant_found && !empty_in[cand[WIDTH_SEL-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[WIDTH_SEL-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        remaining_d  = remaining_q;
        rd_en        = 1'b0;
        rd_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!(&empty_in)) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (grant_found) begin
                    sel_d        = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_HDR_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR_RD: begin
                if (room) begin
                    rd_en   = 1'b1;
                    state_d = ST_HDR_WAIT;
                end
            end
            ST_HDR_WAIT: begin
                remaining_d = hdr_len;
                state_d     = (hdr_len == '0) ? ST_DONE : ST_BODY;
            end
            ST_BODY: begin
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else if (room) begin
                    rd_en       = 1'b1;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                end
            end
            ST_DONE: begin
                rd_done = 1'b1;
                state_d = ST_GAP;
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign last_d    = rd_en && (state_q == ST_BODY) && (remaining_q == LEN_WIDTH'(1));
    assign push_sop  = (state_q == ST_HDR_WAIT);
    assign push_eop  = push_sop ? (hdr_len == '0) : last_q;
    assign push_word = {push_sop, push_eop, sel_q, data_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            last_grant_q <= WIDTH_SEL'(PORT_NUB_TOTAL - 1);
            remaining_q  <= '0;
            inflight_q   <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            remaining_q  <= remaining_d;
            inflight_q   <= rd_en;
            last_q       <= last_d;
        end
    end

    out_skid_fifo #(.WIDTH(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .valid_o (tx_valid),
        .rdata_o (head_word),
        .count_o (fifo_cnt)
    );

    assign {tx_sop, tx_eop, tx_src, tx_data} = head_word;
    assign rd_sel = sel_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_output_port_reader.sv
// Directed and randomized checks of output_port_reader against per-source packet queues.
module tb_output_port_reader;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  empty_in;
    logic [SW-1:0] rd_sel;
    logic          rd_en, rd_done;
    logic [DW-1:0] data_in;
    logic          tx_valid, tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_sop, tx_eop;
    logic [SW-1:0] tx_src;
    logic          busy;

    output_port_reader #(.PORT_NUB_TOTAL(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .empty_in(empty_in), .rd_sel(rd_sel), .rd_en(rd_en),
        .rd_done(rd_done), .data_in(data_in), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_src(tx_src), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]   src_q [N][$];
    logic [DW+1:0]   exp_q [N][$];
    int              pkt_cnt [N];
    int              n_cmp = 0, n_err = 0;
    int              cyc = 0, n_rd_en = 0, n_rd_done = 0, issued = 0, accepted = 0;
    int              acc_cyc[$], rd_cyc[$], sop_src[$];
    int              rdy_mode = 0;
    logic            in_pkt = 1'b0;
    logic [SW-1:0]   cur_src = '0;
    logic            stall_q = 1'b0;
    logic [DW+SW+1:0] stall_word = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_grant(input int last, input logic [N-1:0] m);
        next_grant = -1;
        for (int k = 1; k <= N; k++)
            if (next_grant < 0 && m[(last + k) % N]) next_grant = (last + k) % N;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic load_pkt(input int s, input int len);
        logic [DW-1:0] w;
        w = {8'($urandom), 8'(len)};
        src_q[s].push_back(w);
        exp_q[s].push_back({1'b1, len == 0, w});
        for (int i = 0; i < len; i++) begin
            w = 16'($urandom);
            src_q[s].push_back(w);
            exp_q[s].push_back({1'b0, i == len - 1, w});
        end
        pkt_cnt[s]++;
    endtask

    task automatic clear_model();
        for (int s = 0; s < N; s++) begin
            src_q[s].delete();
            exp_q[s].delete();
            pkt_cnt[s] = 0;
        end
        in_pkt = 1'b0; stall_q = 1'b0; issued = 0; accepted = 0;
    endtask

    function automatic bit all_drained();
        all_drained = 1'b1;
        for (int s = 0; s < N; s++)
            if (exp_q[s].size() != 0 || pkt_cnt[s] != 0) all_drained = 1'b0;
    endfunction

    task automatic drain(input string tag);
        int k; bit done;
        k = 0; done = 1'b0;
        while (!done && k < 3000) begin
            step(1); k++;
            done = !busy && !tx_valid && all_drained();
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Upstream queues: data one cycle after rd_en, empty_in updated one cycle after rd_done.
    initial begin : upstream
        logic pend_rd, pend_done;
        logic [SW-1:0] ps;
        data_in = '0; empty_in = '1;
        forever begin
            @(negedge clk);
            pend_rd = rd_en && !rst; pend_done = rd_done && !rst; ps = rd_sel;
            @(posedge clk); #1;
            if (!rst) begin
                if (pend_rd) begin
                    if (src_q[ps].size() > 0) data_in = src_q[ps].pop_front();
                    else data_in = 16'hdead;
                end
                if (pend_done && pkt_cnt[ps] > 0) pkt_cnt[ps]--;
            end
            for (int s = 0; s < N; s++) empty_in[s] = (pkt_cnt[s] == 0);
        end
    end

    initial begin : sink
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic [DW+1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_q) begin
                    check("stall_valid", 32'(tx_valid), 32'd1);
                    check("stall_word", 32'({tx_sop, tx_eop, tx_src, tx_data}), 32'(stall_word));
                end
                if (rd_en) begin n_rd_en++; issued++; rd_cyc.push_back(cyc); end
                if (rd_done) n_rd_done++;
                if (tx_valid && tx_ready) begin
                    accepted++;
                    acc_cyc.push_back(cyc);
                    if (tx_sop) sop_src.push_back(int'(tx_src));
                    if (exp_q[tx_src].size() > 0) e = exp_q[tx_src].pop_front();
                    else e = 'x;
                    check("tx_data", 32'(tx_data), 32'(e[DW-1:0]));
                    check("tx_sop", 32'(tx_sop), 32'(e[DW+1]));
                    check("tx_eop", 32'(tx_eop), 32'(e[DW]));
                    if (in_pkt) check("pkt_contiguous_src", 32'(tx_src), 32'(cur_src));
                    in_pkt = !tx_eop; cur_src = tx_src;
                end
                if (rd_en) check("outstanding_le_2", 32'(issued - accepted <= 2), 32'd1);
                stall_q = tx_valid && !tx_ready;
                stall_word = {tx_sop, tx_eop, tx_src, tx_data};
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int b_en, b_done, b_acc, k, tot, a0;
        int exp_order[$];
        int last;
        logic [N-1:0] m;

        clear_model();
        rst = 1'b1;
        step(3);
        check("rst_ctrl", 32'({rd_en, rd_done, tx_valid, tx_sop, tx_eop, busy}), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_sel_src", 32'({tx_src, rd_sel}), 32'd0);
        rst = 1'b0;
        step(2);
        check("idle_busy", 32'(busy), 32'd0);

        // Single packet on source 2, sink always ready.
        b_en = n_rd_en; b_done = n_rd_done; b_acc = accepted;
        acc_cyc.delete(); rd_cyc.delete(); sop_src.delete();
        load_pkt(2, 3);
        drain("s1_drain");
        check("s1_words", 32'(accepted - b_acc), 32'd4);
        check("s1_rd_en", 32'(n_rd_en - b_en), 32'd4);
        check("s1_rd_done", 32'(n_rd_done - b_done), 32'd1);
        if (acc_cyc.size() == 4 && rd_cyc.size() > 0 && sop_src.size() > 0) begin
            check("s1_hdr_latency", 32'(acc_cyc[0] - rd_cyc[0]), 32'd2);
            check("s1_body_stream", 32'(acc_cyc[3] - acc_cyc[1]), 32'd2);
            check("s1_src", 32'(sop_src[0]), 32'd2);
        end

        // Round-robin after reset, then refill.
        rst = 1'b1; clear_model(); step(2); rst = 1'b0; step(1);
        sop_src.delete(); exp_order.delete();
        last = N - 1; m = 4'b1011;
        load_pkt(0, 1); load_pkt(1, 1); load_pkt(3, 1);
        repeat (3) begin k = next_grant(last, m); exp_order.push_back(k); m[k] = 1'b0; last = k; end
        drain("rr_drain_a");
        m = 4'b0101;
        load_pkt(0, 1); load_pkt(2, 1);
        repeat (2) begin k = next_grant(last, m); exp_order.push_back(k); m[k] = 1'b0; last = k; end
        drain("rr_drain_b");
        check("rr_count", 32'(sop_src.size()), 32'(exp_order.size()));
        for (int i = 0; i < exp_order.size(); i++)
            if (i < sop_src.size()) check("rr_order", 32'(sop_src[i]), 32'(exp_order[i]));

        // Zero-length packet.
        b_en = n_rd_en; b_done = n_rd_done; b_acc = accepted;
        load_pkt(1, 0);
        drain("zero_drain");
        check("zero_words", 32'(accepted - b_acc), 32'd1);
        check("zero_rd_en", 32'(n_rd_en - b_en), 32'd1);
        check("zero_rd_done", 32'(n_rd_done - b_done), 32'd1);

        // Backpressure: toggling ready, then a hard stall.
        b_en = n_rd_en; b_acc = accepted;
        load_pkt(0, 8);
        rdy_mode = 1; step(8);
        rdy_mode = 3; step(1);
        a0 = accepted; step(4);
        check("stall_no_accept", 32'(accepted - a0), 32'd0);
        check("stall_holds_valid", 32'(tx_valid), 32'd1);
        rdy_mode = 1;
        drain("bp_drain");
        rdy_mode = 0;
        check("bp_words", 32'(accepted - b_acc), 32'd9);
        check("bp_rd_en", 32'(n_rd_en - b_en), 32'd9);

        // Random packets under random backpressure.
        b_en = n_rd_en; b_done = n_rd_done; b_acc = accepted; tot = 0;
        rdy_mode = 2;
        for (int p = 0; p < 12; p++) begin
            k = $urandom_range(0, 5);
            load_pkt($urandom_range(0, N - 1), k);
            tot += k + 1;
            step($urandom_range(0, 6));
        end
        drain("rand_drain");
        rdy_mode = 0;
        check("rand_rd_done", 32'(n_rd_done - b_done), 32'd12);
        check("rand_rd_en", 32'(n_rd_en - b_en), 32'(tot));
        check("rand_words", 32'(accepted - b_acc), 32'(tot));

        // Reset in the middle of a body.
        b_en = n_rd_en; b_done = n_rd_done;
        load_pkt(3, 6);
        k = 0;
        while (n_rd_en - b_en < 4 && k < 200) begin step(1); k++; end
        check("mid_rst_reached", 32'(n_rd_en - b_en >= 4), 32'd1);
        rst = 1'b1; #1;
        check("mid_rst_ctrl", 32'({rd_en, rd_done, tx_valid, tx_sop, tx_eop, busy}), 32'd0);
        check("mid_rst_data", 32'({tx_data, tx_src, rd_sel}), 32'd0);
        check("mid_rst_no_done", 32'(n_rd_done - b_done), 32'd0);
        clear_model();
        step(2);
        sop_src.delete();
        load_pkt(2, 1); load_pkt(0, 1);
        rst = 1'b0;
        drain("post_rst_drain");
        check("post_rst_grants", 32'(sop_src.size()), 32'd2);
        if (sop_src.size() > 0) check("post_rst_first", 32'(sop_src[0]), 32'(next_grant(N - 1, 4'b0101)));

        // Single packet: the GAP cycle must keep source 1 from being granted twice.
        b_en = n_rd_en; b_done = n_rd_done;
        sop_src.delete();
        load_pkt(1, 2);
        k = 0;
        while (n_rd_done == b_done && k < 200) begin step(1); k++; end
        step(20);
        check("gap_grants", 32'(sop_src.size()), 32'd1);
        check("gap_rd_en", 32'(n_rd_en - b_en), 32'd3);
        check("gap_rd_done", 32'(n_rd_done - b_done), 32'd1);
        check("gap_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
